dec_decode_arbiter: RTL

DEC_DECODE_ARBITER -- requirements
Module: dec_decode_arbiter

---
 rtl/dec_decode_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dec_decode_arbiter.sv
// rtl/dec_decode_arbiter.sv - round-robin arbiter sharing one external 4-to-10 decoder between two requesters
module dec_decode_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_code,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_code,
    output logic       req1_ready,
    output logic [3:0] dec_a,
    output logic       dec_c,
    input  logic [9:0] dec_b,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [9:0] rsp_onehot,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

    state_t     state;
    state_t     state_next;
    logic       ptr;
    logic [3:0] code_q;
    logic       id_q;
    logic [3:0] cnt;
    logic       grant_id;
    logic       accept;
    logic       handshake;

    // Preferred requester wins when valid; otherwise the other one is taken.
    always_comb begin
        grant_id = ptr;
        if (ptr == 1'b0) begin
            grant_id = req0_valid ? 1'b0 : 1'b1;
        end else begin
            grant_id = req1_valid ? 1'b1 : 1'b0;
        end
    end

    assign accept    = (state == IDLE) && (req0_valid || req1_valid) && !rst;
    assign handshake = (state == RESP) && rsp_ready;

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        dec_a      = 4'd0;
        dec_c      = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = accept && !grant_id;
                req1_ready = accept && grant_id;
                if (accept) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                dec_a = code_q;
                dec_c = 1'b0;
                if (cnt == 4'd0) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                dec_a      = code_q;
                dec_c      = 1'b0;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 1'b0;
            code_q     <= 4'd0;
            id_q       <= 1'b0;
            cnt        <= 4'd0;
            rsp_onehot <= 10'd0;
            rsp_err    <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (accept) begin
                code_q <= grant_id ? req1_code : req0_code;
                id_q   <= grant_id;
                cnt    <= 4'(SETTLE - 1);
            end else if (state == DRIVE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == SAMPLE) begin
                rsp_onehot <= dec_b;
                rsp_err    <= (code_q > 4'd9) || ($countones(dec_b) != 1);
            end
            if (handshake) begin
                ptr <= ~id_q;
                if (rsp_err && err_count != 8'hff) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign rsp_id = id_q;

endmodule
